// File: rtl/div_pkg.sv
// div_pkg: state type, default widths and saturation quotients shared by the div32by16 slice.
package div_pkg;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  localparam int DSIZE_DEF = 32;
  localparam int VSIZE_DEF = 16;
  localparam logic [31:0] SAT_POS = 32'h7FFF_FFFF;
  localparam logic [31:0] SAT_NEG = 32'h8000_0000;
endpackage

// File: rtl/div_step.sv
// div_step: one combinational restoring compare-subtract bit of a long division.
module div_step #(
  parameter int W = 16
) (
  input  logic [W-1:0] rem_i,
  input  logic         bit_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] rem_o,
  output logic         q_o
);
  logic [W:0] trial;
  always_comb begin
    trial = {rem_i, bit_i};
    q_o = trial >= {1'b0, d_i};
    rem_o = q_o ? W'(trial - {1'b0, d_i}) : trial[W-1:0];
  end
endmodule

// File: rtl/div32by16.sv
// div32by16: sequential restoring divider, signed/unsigned dividend by unsigned divisor.
// Define DIV32BY16_ROUND_EN to round the quotient half away from zero.
module div32by16 import div_pkg::*; #(
  parameter int DSIZE = DSIZE_DEF,
  parameter int VSIZE = VSIZE_DEF,
  parameter int D_SIGNED = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ce,
  input  logic             start,
  input  logic [DSIZE-1:0] a,
  input  logic [VSIZE-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [DSIZE-1:0] q,
  output logic [VSIZE:0]   r,
  output logic             dz
);
  localparam int CW = $clog2(DSIZE) + 1;
  localparam logic [DSIZE-1:0] Q_MIN = {1'b1, {(DSIZE-1){1'b0}}};
  localparam logic [DSIZE-1:0] Q_MAX = {1'b0, {(DSIZE-1){1'b1}}};
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DSIZE-1:0] quo_q, quo_d, q_q, q_d, mag, a_abs, sat;
  logic [VSIZE-1:0] rem_q, rem_d, b_q, b_d, step_rem;
  logic [VSIZE:0] r_q, r_d;
  logic neg_q, neg_d, dzw_q, dzw_d, busy_q, busy_d, done_q, done_d, dz_q, dz_d, a_neg, step_q;
  div_step #(.W(VSIZE)) u_step (
    .rem_i(rem_q),
    .bit_i(quo_q[DSIZE-1]),
    .d_i(b_q),
    .rem_o(step_rem),
    .q_o(step_q)
  );
  always_comb begin
    a_neg = (D_SIGNED != 0) && a[DSIZE-1];
    a_abs = a_neg ? -a : a;
    sat = (D_SIGNED == 0) ? '1 : (neg_q ? Q_MIN : Q_MAX);
`ifdef DIV32BY16_ROUND_EN
    mag = quo_q + DSIZE'({rem_q, 1'b0} >= {1'b0, b_q});
`else
    mag = quo_q;
`endif
  end
  // quo_q doubles as dividend shifter (MSB out) and quotient collector (LSB in)
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    quo_d = quo_q;
    rem_d = rem_q;
    b_d = b_q;
    neg_d = neg_q;
    dzw_d = dzw_q;
    busy_d = busy_q;
    done_d = 1'b0;
    q_d = q_q;
    r_d = r_q;
    dz_d = dz_q;
    case (state_q)
      IDLE: if (start) begin
        neg_d = a_neg;
        quo_d = a_abs;
        b_d = b;
        rem_d = '0;
        cnt_d = '0;
        dzw_d = b == '0;
        busy_d = 1'b1;
        state_d = (b == '0) ? DONE : CALC;
      end
      CALC: begin
        quo_d = {quo_q[DSIZE-2:0], step_q};
        rem_d = step_rem;
        cnt_d = cnt_q + CW'(1);
        state_d = (cnt_q == CW'(DSIZE-1)) ? DONE : CALC;
      end
      DONE: begin
        state_d = IDLE;
        busy_d = 1'b0;
        done_d = 1'b1;
        dz_d = dzw_q;
        q_d = dzw_q ? sat : (neg_q ? -mag : mag);
        r_d = dzw_q ? '0 : (neg_q ? -{1'b0, rem_q} : {1'b0, rem_q});
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      quo_q <= '0;
      rem_q <= '0;
      b_q <= '0;
      neg_q <= 1'b0;
      dzw_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      q_q <= '0;
      r_q <= '0;
      dz_q <= 1'b0;
    end else if (ce) begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      quo_q <= quo_d;
      rem_q <= rem_d;
      b_q <= b_d;
      neg_q <= neg_d;
      dzw_q <= dzw_d;
      busy_q <= busy_d;
      done_q <= done_d;
      q_q <= q_d;
      r_q <= r_d;
      dz_q <= dz_d;
    end
  end
  assign busy = busy_q;
  assign done = done_q;
  assign q = q_q;
  assign r = r_q;
  assign dz = dz_q;
endmodule

// File: doc/div32by16.md
DIV32BY16 -- requirements
Module: div32by16

Interface
REQ-001 SHALL have parameter DSIZE, default 32: dividend and quotient width.
REQ-002 SHALL have parameter VSIZE, default 16: divisor width.
REQ-003 SHALL have parameter D_SIGNED, default 1: 1 means the dividend is two's complement, 0 means it is unsigned; the divisor is always unsigned.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port ce, input, 1 bit: clock enable; when ce=0 all state holds.
REQ-007 SHALL have port start, input, 1 bit: request; sampled only in IDLE with ce=1.
REQ-008 SHALL have port a, input, DSIZE bits: dividend.
REQ-009 SHALL have port b, input, VSIZE bits: divisor.
REQ-010 SHALL have port busy, output, 1 bit: high from start acceptance until done.
REQ-011 SHALL have port done, output, 1 bit: single-cycle pulse marking q, r and dz valid.
REQ-012 SHALL have port q, output, DSIZE bits: quotient.
REQ-013 SHALL have port r, output, VSIZE+1 bits: signed remainder.
REQ-014 SHALL have port dz, output, 1 bit: divide-by-zero flag, valid with done.

Function
REQ-015 SHALL implement FSM states IDLE, CALC and DONE.
REQ-016 IDLE SHALL go to CALC on start with ce=1 and b!=0, latching |a|, the sign of a, and b.
REQ-017 IDLE SHALL go to DONE on start with ce=1 and b==0.
REQ-018 CALC SHALL perform one restoring compare-subtract step per enabled cycle, MSB first, for exactly DSIZE steps, then go to DONE.
REQ-019 DONE SHALL pulse done for one cycle with busy low, update q, r and dz, and return to IDLE.
REQ-020 SHALL assert done DSIZE+2 enabled cycles after the start-sampling edge, which is 34 for default parameters.
REQ-021 With b==0, done SHALL assert 2 enabled cycles after the start-sampling edge.
REQ-022 SHALL truncate the quotient toward zero; r SHALL take the sign of a, with |r| < b.
REQ-023 |a| SHALL be computed in DSIZE unsigned bits, so a = -2^(DSIZE-1) with b=1 gives q = 0x80000000 and no overflow.
REQ-024 For divide-by-zero SHALL set dz=1, r=0, and q=0x7FFFFFFF if a>=0 or 0x80000000 if a<0 (unsigned mode: all ones).
REQ-025 SHALL ignore start while busy; a and b SHALL NOT be sampled again until IDLE.
REQ-026 When ce=0 in any state, the FSM, step counter and outputs SHALL hold, including stretching done if ce=0 in DONE.
REQ-027 q, r and dz SHALL hold their values between done pulses.

Reset
REQ-028 rst_n=0 SHALL immediately force IDLE, busy=0, done=0, q=0, r=0, dz=0, and clear the step counter, including mid-CALC.
REQ-029 An operation interrupted by reset SHALL produce no done; release SHALL be glitch-free, and start is accepted on the first clk edge after release.

Configuration
REQ-030 Macro DIV32BY16_ROUND_EN defined: if 2*|r| >= b, |q| SHALL be incremented before the sign is applied (round half away from zero), with no change in latency; r SHALL remain the truncated remainder.
REQ-031 Macro DIV32BY16_ROUND_EN undefined: q SHALL be truncated as in REQ-022, and no rounding logic SHALL be present.

Structure
REQ-032 Package div_pkg SHALL hold the state typedef, the DSIZE/VSIZE defaults and the saturation constants.
REQ-033 Sub-module div_step SHALL contain only the combinational single-bit compare-subtract.

Verification
REQ-034 a=1000, b=7, start -> done at cycle 34 with q=142, r=6, dz=0; q=143 with DIV32BY16_ROUND_EN.
REQ-035 a=-1000, b=7 -> q=-142, r=-6; q=-143 with DIV32BY16_ROUND_EN.
REQ-036 a=0x80000000, b=1 -> q=0x80000000, r=0; a=5, b=0 -> done at cycle 2 with dz=1, q=0x7FFFFFFF, r=0.
REQ-037 ce=0 for 5 cycles mid-CALC -> done at cycle 39; start pulse while busy -> ignored, exactly one done.
REQ-038 rst_n=0 at cycle 10 of CALC -> all outputs 0 at once, no done; the next start completes normally.
